// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan: active-low row strobe scanner with framed key image and single-key event handshake.
// Optional auto-repeat of the held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_matrix_scan #(
    parameter int ROWS     = 5,
    parameter int COLS     = 5,
    parameter int SCAN_DIV = 1000,
    parameter int CODE_W   = 5
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_FRAMES = 50
`endif
) (
    input  logic                 clk,
    input  logic                 RSTN,
    input  logic [COLS-1:0]      col_in,
    output logic [ROWS-1:0]      row_out,
    output logic [ROWS*COLS-1:0] btn_out,
    output logic                 frame_done,
    output logic                 key_valid,
    output logic [CODE_W-1:0]    key_code,
    input  logic                 key_ack,
    output logic                 overrun,
    input  logic                 ovr_clr
);
    localparam int N  = ROWS * COLS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {DRIVE, SAMPLE, COMMIT} state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       div_q, div_d;
    logic [RW-1:0]       row_q, row_d;
    logic [COLS-1:0]     sync1_q, sync2_q;
    logic [N-1:0]        shadow_q, shadow_d;
    logic [N-1:0]        btn_q, btn_d;
    logic                frame_done_q;
    logic                key_valid_q, key_valid_d;
    logic [CODE_W-1:0]   key_code_q, key_code_d;
    logic                overrun_q, overrun_d;
    logic                do_sample, do_commit, last_row;
    logic [N-1:0]        new_press;
    logic                has_new, ev_fire, slot_free, rpt_fire;
    logic [CODE_W-1:0]   low_idx, ev_code;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) state_q <= DRIVE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DRIVE:   state_d = (div_q == DW'(SCAN_DIV - 2)) ? SAMPLE : DRIVE;
            SAMPLE:  state_d = last_row ? COMMIT : DRIVE;
            default: state_d = DRIVE;
        endcase
    end

    always_comb begin
        do_sample = state_q == SAMPLE;
        do_commit = state_q == COMMIT;
        last_row  = row_q == RW'(ROWS - 1);
        div_d     = (state_q == DRIVE) ? div_q + 1'b1 : '0;
        row_d     = (do_sample && !last_row) ? row_q + 1'b1 : do_commit ? '0 : row_q;
        btn_d     = do_commit ? shadow_q : btn_q;
        shadow_d  = shadow_q;
        for (int r = 0; r < ROWS; r++)
            if (do_sample && row_q == RW'(r)) shadow_d[r*COLS +: COLS] = sync2_q;
    end

    // Lowest newly pressed index wins; higher simultaneous presses are silently dropped.
    always_comb begin
        new_press = shadow_q & ~btn_q;
        has_new   = |new_press;
        low_idx   = '0;
        for (int i = N - 1; i >= 0; i--)
            if (new_press[i]) low_idx = CODE_W'(i);
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RCW = $clog2(REPEAT_FRAMES + 1);
    logic [RCW-1:0] rpt_q, rpt_d;
    logic           rpt_hold;

    always_comb begin
        rpt_hold = (shadow_q == btn_q) && (btn_q == (N'(1) << key_code_q));
        rpt_fire = rpt_hold && (rpt_q == RCW'(REPEAT_FRAMES - 1));
        rpt_d    = !do_commit ? rpt_q : (rpt_hold && !rpt_fire) ? rpt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) rpt_q <= '0;
        else       rpt_q <= rpt_d;
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        ev_fire     = do_commit && (has_new || rpt_fire);
        ev_code     = has_new ? low_idx : key_code_q;
        slot_free   = !key_valid_q || key_ack;
        key_valid_d = (ev_fire && slot_free) || (key_valid_q && !key_ack);
        key_code_d  = (ev_fire && slot_free) ? ev_code : key_code_q;
        overrun_d   = (ev_fire && !slot_free) || (overrun_q && !ovr_clr);
    end

    // Synchroniser stores columns already inverted, so 1 = key closed.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            div_q        <= '0;
            row_q        <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            shadow_q     <= '0;
            btn_q        <= '0;
            frame_done_q <= 1'b0;
            key_valid_q  <= 1'b0;
            key_code_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            div_q        <= div_d;
            row_q        <= row_d;
            sync1_q      <= ~col_in;
            sync2_q      <= sync1_q;
            shadow_q     <= shadow_d;
            btn_q        <= btn_d;
            frame_done_q <= do_commit;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            overrun_q    <= overrun_d;
        end
    end

    assign row_out    = ~(ROWS'(1) << row_q);
    assign btn_out    = btn_q;
    assign frame_done = frame_done_q;
    assign key_valid  = key_valid_q;
    assign key_code   = key_code_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_keypad_matrix_scan.sv
// tb_keypad_matrix_scan: directed table plus hand sequences for the 5x5 keypad scanner at SCAN_DIV=4.
module tb_keypad_matrix_scan;
    localparam int ROWS = 5;
    localparam int COLS = 5;
    localparam int N    = 25;
    localparam int CW   = 5;

    logic            clk = 1'b0;
    logic            RSTN = 1'b0;
    logic [COLS-1:0] col_in;
    logic [ROWS-1:0] row_out;
    logic [N-1:0]    btn_out;
    logic            frame_done, key_valid, overrun;
    logic            key_ack = 1'b0;
    logic            ovr_clr = 1'b0;
    logic [CW-1:0]   key_code;
    logic [N-1:0]    pressed = '0;
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    keypad_matrix_scan #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .CODE_W(CW)
`ifdef KEYPAD_REPEAT_EN
        , .REPEAT_FRAMES(3)
`endif
    ) dut (
        .clk(clk), .RSTN(RSTN), .col_in(col_in), .row_out(row_out), .btn_out(btn_out),
        .frame_done(frame_done), .key_valid(key_valid), .key_code(key_code),
        .key_ack(key_ack), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always_comb begin
        col_in = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!row_out[r] && pressed[r*COLS+c]) col_in[c] = 1'b0;
    end

    typedef struct {
        logic [N-1:0]  keys;
        logic          ack;
        logic          clr;
        logic [N-1:0]  btn;
        logic          valid;
        logic [CW-1:0] code;
        logic          ovr;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input logic ack, input logic clr);
        int n;
        n = 0;
        key_ack = ack;
        ovr_clr = clr;
        do begin
            @(negedge clk);
            n++;
            key_ack = 1'b0;
            ovr_clr = 1'b0;
        end while (!frame_done && n < 60);
        chk("frame_period", n, 21);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [ROWS-1:0] er;
        int p;
        tbl[0] = '{25'h0002000, 1'b0, 1'b0, 25'h0002000, 1'b1, 5'd13, 1'b0};
        tbl[1] = '{25'h0002000, 1'b1, 1'b0, 25'h0002000, 1'b0, 5'd13, 1'b0};
        tbl[2] = '{25'h0002000, 1'b0, 1'b0, 25'h0002000, 1'b0, 5'd13, 1'b0};
        tbl[3] = '{25'h0100080, 1'b0, 1'b0, 25'h0100080, 1'b1, 5'd7,  1'b0};
        tbl[4] = '{25'h0000000, 1'b1, 1'b0, 25'h0000000, 1'b0, 5'd7,  1'b0};
        tbl[5] = '{25'h0000010, 1'b0, 1'b0, 25'h0000010, 1'b1, 5'd4,  1'b0};
        tbl[6] = '{25'h0000000, 1'b0, 1'b0, 25'h0000000, 1'b1, 5'd4,  1'b0};
        tbl[7] = '{25'h0000200, 1'b0, 1'b0, 25'h0000200, 1'b1, 5'd4,  1'b1};
        tbl[8] = '{25'h0000200, 1'b0, 1'b1, 25'h0000200, 1'b1, 5'd4,  1'b0};
        tbl[9] = '{25'h0000000, 1'b1, 1'b0, 25'h0000000, 1'b0, 5'd4,  1'b0};

        repeat (3) @(negedge clk);
        chk("rst_row", row_out, 5'b11110);
        chk("rst_btn", btn_out, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_fd", frame_done, 0);

        pressed = 25'h0002000;
        RSTN = 1'b1;
        repeat (30) @(negedge clk);
        chk("pre_btn", btn_out, 25'h0002000);
        chk("pre_valid", key_valid, 1);
        #2 RSTN = 1'b0;
        #1;
        chk("mid_rst_row", row_out, 5'b11110);
        chk("mid_rst_btn", btn_out, 0);
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_code", key_code, 0);
        chk("mid_rst_ovr", overrun, 0);
        pressed = '0;
        @(negedge clk);
        RSTN = 1'b1;
        chk("rel_row", row_out, 5'b11110);
        for (int n = 1; n <= 42; n++) begin
            @(negedge clk);
            p  = n % 21;
            er = ~(5'b00001 << ((p == 20) ? 4 : p / 4));
            chk($sformatf("step%0d_row", n), row_out, er);
            chk($sformatf("step%0d_fd", n), frame_done, (p == 0) ? 1 : 0);
        end

        for (int i = 0; i < 10; i++) begin
            pressed = tbl[i].keys;
            run_frame(tbl[i].ack, tbl[i].clr);
            chk($sformatf("v%0d_btn", i), btn_out, tbl[i].btn);
            chk($sformatf("v%0d_valid", i), key_valid, tbl[i].valid);
            chk($sformatf("v%0d_code", i), key_code, tbl[i].code);
            chk($sformatf("v%0d_ovr", i), overrun, tbl[i].ovr);
        end

        pressed = 25'h0000004;
        run_frame(1'b0, 1'b0);
        chk("pend_valid", key_valid, 1);
        chk("pend_code", key_code, 2);
        pressed = 25'h0000800;
        repeat (20) @(negedge clk);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        chk("race_fd", frame_done, 1);
        chk("race_valid", key_valid, 1);
        chk("race_code", key_code, 11);
        chk("race_btn", btn_out, 25'h0000800);
        chk("race_ovr", overrun, 0);
        run_frame(1'b1, 1'b0);
        chk("race_ack_valid", key_valid, 0);
        run_frame(1'b1, 1'b0);
        chk("idle_ack_valid", key_valid, 0);
        chk("idle_ack_code", key_code, 11);

        pressed = 25'h0000001;
        run_frame(1'b0, 1'b0);
        chk("rpt_first_valid", key_valid, 1);
        chk("rpt_first_code", key_code, 0);
        chk("rpt_first_btn", btn_out, 1);
        for (int i = 1; i <= 6; i++) begin
            run_frame(1'b1, 1'b0);
`ifdef KEYPAD_REPEAT_EN
            chk($sformatf("rpt%0d_valid", i), key_valid, (i % 3 == 0) ? 1 : 0);
`else
            chk($sformatf("rpt%0d_valid", i), key_valid, 0);
`endif
            chk($sformatf("rpt%0d_code", i), key_code, 0);
            chk($sformatf("rpt%0d_ovr", i), overrun, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
